// File: rtl/binario_a_bcd_2dig.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for
// up to two decimal digits plus a hundreds bit, with threshold/range flags.
module binario_a_bcd_2dig #(
    parameter int unsigned ANCHO  = 7,
    parameter int unsigned UMBRAL = 63,
    parameter int unsigned LIMITE = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [ANCHO-1:0] valor,
    output logic             ocupado,
    output logic             valido,
    output logic             centenas,
    output logic [3:0]       decenas,
    output logic [3:0]       unidades,
    output logic             mayor_umbral,
    output logic             fuera_rango
);

    typedef enum logic {REPOSO, DESPLAZA} estado_t;

    localparam int unsigned    CW     = $clog2(ANCHO);
    localparam logic [CW-1:0]  ULTIMO = CW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_c_q, acc_c_d;
    logic [3:0]       acc_d_q, acc_d_d;
    logic [3:0]       acc_u_q, acc_u_d;
    logic             hold_mu_q, hold_mu_d;
    logic             hold_fr_q, hold_fr_d;
    logic             centenas_q, centenas_d;
    logic [3:0]       decenas_q, decenas_d;
    logic [3:0]       unidades_q, unidades_d;
    logic             mayor_q, mayor_d;
    logic             fuera_q, fuera_d;
    logic             valido_q, valido_d;

    logic [3:0] u_aj, d_aj;
    logic [3:0] sh_u, sh_d;
    logic       sh_c;

    // Add-3 correction precedes the shift; hundreds takes only the tens carry.
    always_comb begin
        u_aj = (acc_u_q >= 4'd5) ? acc_u_q + 4'd3 : acc_u_q;
        d_aj = (acc_d_q >= 4'd5) ? acc_d_q + 4'd3 : acc_d_q;
        sh_u = {u_aj[2:0], sr_q[ANCHO-1]};
        sh_d = {d_aj[2:0], u_aj[3]};
        sh_c = d_aj[3];
    end

    always_comb begin
        estado_d   = estado_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        acc_c_d    = acc_c_q;
        acc_d_d    = acc_d_q;
        acc_u_d    = acc_u_q;
        hold_mu_d  = hold_mu_q;
        hold_fr_d  = hold_fr_q;
        centenas_d = centenas_q;
        decenas_d  = decenas_q;
        unidades_d = unidades_q;
        mayor_d    = mayor_q;
        fuera_d    = fuera_q;
        valido_d   = 1'b0;
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    sr_d      = valor;
                    acc_c_d   = 1'b0;
                    acc_d_d   = 4'd0;
                    acc_u_d   = 4'd0;
                    hold_mu_d = 32'(valor) > UMBRAL;
                    hold_fr_d = 32'(valor) > LIMITE;
                    cnt_d     = '0;
                    estado_d  = DESPLAZA;
                end
            end
            DESPLAZA: begin
                sr_d    = {sr_q[ANCHO-2:0], 1'b0};
                acc_u_d = sh_u;
                acc_d_d = sh_d;
                acc_c_d = sh_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ULTIMO) begin
                    estado_d   = REPOSO;
                    centenas_d = sh_c;
                    decenas_d  = sh_d;
                    unidades_d = sh_u;
                    mayor_d    = hold_mu_q;
                    fuera_d    = hold_fr_q;
                    valido_d   = 1'b1;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= REPOSO;
            sr_q       <= '0;
            cnt_q      <= '0;
            acc_c_q    <= 1'b0;
            acc_d_q    <= 4'd0;
            acc_u_q    <= 4'd0;
            hold_mu_q  <= 1'b0;
            hold_fr_q  <= 1'b0;
            centenas_q <= 1'b0;
            decenas_q  <= 4'd0;
            unidades_q <= 4'd0;
            mayor_q    <= 1'b0;
            fuera_q    <= 1'b0;
            valido_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            acc_c_q    <= acc_c_d;
            acc_d_q    <= acc_d_d;
            acc_u_q    <= acc_u_d;
            hold_mu_q  <= hold_mu_d;
            hold_fr_q  <= hold_fr_d;
            centenas_q <= centenas_d;
            decenas_q  <= decenas_d;
            unidades_q <= unidades_d;
            mayor_q    <= mayor_d;
            fuera_q    <= fuera_d;
            valido_q   <= valido_d;
        end
    end

    assign ocupado      = (estado_q == DESPLAZA);
    assign valido       = valido_q;
    assign centenas     = centenas_q;
    assign decenas      = decenas_q;
    assign unidades     = unidades_q;
    assign mayor_umbral = mayor_q;
    assign fuera_rango  = fuera_q;

endmodule

// File: tb/tb_binario_a_bcd_2dig.sv
// Scoreboard bench: driver queues expected digits/flags/cycle per accepted
// start; a monitor pops and compares on every valido pulse.
module tb_binario_a_bcd_2dig;

    localparam int unsigned ANCHO = 7;
    localparam int unsigned LAT   = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             inicio;
    logic [ANCHO-1:0] valor;
    logic             ocupado;
    logic             valido;
    logic             centenas;
    logic [3:0]       decenas;
    logic [3:0]       unidades;
    logic             mayor_umbral;
    logic             fuera_rango;

    typedef struct {
        logic [10:0] res;
        int          ciclo;
        int          v;
    } esperado_t;

    esperado_t cola[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    binario_a_bcd_2dig dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .valor        (valor),
        .ocupado      (ocupado),
        .valido       (valido),
        .centenas     (centenas),
        .decenas      (decenas),
        .unidades     (unidades),
        .mayor_umbral (mayor_umbral),
        .fuera_rango  (fuera_rango)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain decimal arithmetic on the captured value.
    function automatic logic [10:0] modelo(input int v);
        logic       c;
        logic [3:0] d, u;
        c = (v / 100) != 0;
        d = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {c, d, u, v > 63, v > 99};
    endfunction

    task automatic chk(input string nombre, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valido) begin
            if (cola.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valido: got valido=1 expected none at cycle %0d", cyc);
            end else begin
                esperado_t e;
                e = cola.pop_front();
                chk($sformatf("result_v%0d", e.v),
                    int'({centenas, decenas, unidades, mayor_umbral, fuera_rango}),
                    int'(e.res));
                chk($sformatf("latency_v%0d", e.v), cyc, e.ciclo);
                chk("ocupado_at_valido", int'(ocupado), 0);
            end
        end
    end

    // Present a start; the next rising edge accepts it (caller ensures idle).
    task automatic arrancar(input int v, input bit esperar);
        esperado_t e;
        inicio = 1'b1;
        valor  = ANCHO'(v);
        @(posedge clk);
        #1;
        inicio = 1'b0;
        valor  = ANCHO'($urandom);
        if (esperar) begin
            e.res   = modelo(v);
            e.ciclo = cyc + LAT;
            e.v     = v;
            cola.push_back(e);
        end
    endtask

    task automatic esperar_valido();
        bit visto = 1'b0;
        for (int i = 0; i < 3 * LAT && !visto; i++) begin
            @(negedge clk);
            if (valido) visto = 1'b1;
        end
        if (!visto) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no valido expected one within %0d cycles", 3 * LAT);
        end
    endtask

    initial begin
        reset  = 1'b1;
        inicio = 1'b0;
        valor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            int'({ocupado, valido, centenas, decenas, unidades, mayor_umbral, fuera_rango}), 0);

        arrancar(0, 1'b1);
        chk("ocupado_after_start", int'(ocupado), 1);
        esperar_valido();

        // Back-to-back starts launched on the valido cycle.
        arrancar(63, 1'b1);
        esperar_valido();
        arrancar(64, 1'b1);
        esperar_valido();
        arrancar(99, 1'b1);
        esperar_valido();
        arrancar(100, 1'b1);
        esperar_valido();
        arrancar(127, 1'b1);
        esperar_valido();

        // A request while busy must be dropped.
        @(negedge clk);
        arrancar(45, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        inicio = 1'b1;
        valor  = 7'd12;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        esperar_valido();
        repeat (LAT + 3) @(negedge clk);

        // Reset mid-conversion aborts without valido.
        arrancar(88, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs",
            int'({ocupado, valido, centenas, decenas, unidades, mayor_umbral, fuera_rango}), 0);
        repeat (LAT + 3) @(negedge clk);
        arrancar(17, 1'b1);
        esperar_valido();

        for (int v = 0; v < 128; v++) begin
            arrancar(v, 1'b1);
            esperar_valido();
        end

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
            arrancar(int'($urandom_range(0, 127)), 1'b1);
            esperar_valido();
        end

        repeat (LAT + 2) @(negedge clk);
        chk("queue_drained", cola.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
